// File: rtl/fs_digit_serial_seq_if.sv
// rtl/fs_digit_serial_seq_if.sv - request/result bundle for the digit-serial subtractor
interface fs_digit_serial_seq_if #(
  parameter int DIGITS = 4
);
  localparam int W = 3 * DIGITS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         brr;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, brr
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, brr
  );
endinterface

// File: rtl/fs_digit_serial_seq.sv
// rtl/fs_digit_serial_seq.sv - digit-serial a - b - bin sequencer
// One 3-bit full-subtract slice is reused LSD-first, one digit per clock.
module fs_digit_serial_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fs_digit_serial_seq_if.slave  bus
);
  localparam int W  = 3 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_borrow;
  logic [W-1:0]  r_diff;
  logic          r_brr;
  logic          r_busy;
  logic          r_done;

  logic [2:0]    w_d;
  logic [3:0]    w_c;
  logic          w_last;
  logic [W-1:0]  w_diff_upd;
  logic [1:0]    w_state_nxt;

  // Operand registers shift right each RUN edge, so the active digit is always [2:0].
  always_comb begin
    w_d    = 3'b000;
    w_c    = 4'b0000;
    w_c[0] = r_borrow;
    for (int i = 0; i < 3; i++) begin
      w_d[i]   = r_a[i] ^ r_b[i] ^ w_c[i];
      w_c[i+1] = (~r_a[i] & r_b[i]) | (~(r_a[i] ^ r_b[i]) & w_c[i]);
    end
  end

  assign w_last = (r_cnt == LAST);

  always_comb begin
    w_diff_upd = r_diff;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_cnt == CW'(k)) begin
        w_diff_upd[3*k +: 3] = w_d;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_brr    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= bus.bin;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_brr    <= 1'b0;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> 3;
          r_b      <= r_b >> 3;
          r_borrow <= w_c[3];
          r_diff   <= w_diff_upd;
          if (w_last) begin
            r_brr <= w_c[3];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.brr  = r_brr;
endmodule

// File: doc/fs_digit_serial_seq.md
Name: fs_digit_serial_seq

Overview:
Digit-serial subtraction sequencer. It computes a full-width a - b - bin by stepping one shared 3-bit full-subtract slice across the operands, least-significant digit first, one digit per clock. A registered borrow carries between digits. The block sits beside the combinational subtractor family and trades latency for area on wide operands, with a start/busy/done handshake to the requesting logic.

Parameters:
DIGITS, 4, number of 3-bit digits per operand; must be at least 1.
W, 3*DIGITS, operand and result width; derived, not overridable.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request a new subtraction; sampled only in IDLE
a  input  W  minuend; sampled on the accepted start edge only
b  input  W  subtrahend; sampled on the accepted start edge only
bin  input  1  initial borrow-in; sampled on the accepted start edge only
busy  output  1  high while an operation is in flight (RUN or DONE)
done  output  1  one-cycle pulse; diff and brr are valid
diff  output  W  result, a - b - bin mod 2^W
brr  output  1  final borrow-out; 1 when a < b + bin, unsigned

Behaviour:
- Reset: clk and rst_n are the only clock and reset. When rst_n is low at a rising clk edge: state=IDLE, digit counter=0, busy=0, done=0, diff=0, brr=0, internal operand and borrow registers=0. Reset has priority over every other event, including mid-RUN. An aborted operation produces no done.
- FSM states and transitions:
  - IDLE -> RUN when start=1.
  - RUN -> RUN while cnt < DIGITS-1.
  - RUN -> DONE on the edge that processes digit DIGITS-1.
  - DONE -> IDLE unconditionally.
- Accept edge (IDLE, start=1):
  - latch a, b into operand shift registers and bin into the borrow register
  - cnt=0; clear diff and brr to 0
- RUN edge (one edge per digit k = cnt):
  - slice computes {bo, d} = a[3k+2:3k] - b[3k+2:3k] - borrow, with d 3 bits and bo 1 bit
  - diff[3k+2:3k] <= d; borrow <= bo; cnt <= cnt+1
  - on the last digit, also brr <= bo
- Slice equations:
  - per bit: d_i = a_i ^ b_i ^ c_i
  - per bit: c_(i+1) = (~a_i & b_i) | (~(a_i ^ b_i) & c_i)
  - c_0 = stored borrow; bo = c_3
- Outputs:
  - busy = (state != IDLE), registered from state
  - done = 1 only while state == DONE
- Latency: if start is accepted at edge E0, RUN edges are E1..E_DIGITS. done is high for exactly the cycle after edge E_DIGITS. busy is high from E0 until E_DIGITS+1. Minimum start-to-start spacing is DIGITS+2 cycles.
- Result hold: diff and brr hold their final values after done until the next accepted start. During RUN, diff shows partial results and is not valid.
- start while busy (RUN or DONE): ignored; operands are not resampled.
- start held high continuously: the next operation is accepted in the IDLE cycle after DONE.
- Operand inputs a, b, bin may change freely while busy without affecting the result.
- Wrap-around: the result is modulo 2^W, and brr flags the underflow. The cnt width is clog2(DIGITS), with a minimum of 1 bit.

Test Plan:
1. DIGITS=4; a=100, b=37, bin=0; start pulsed at E0 -> busy high after E0; done high only in the cycle after E4; diff=63, brr=0. Both hold through 3 idle cycles after done.
2. a=5, b=9, bin=0 -> diff=12'hFFC, brr=1. Then a=0, b=0, bin=1 -> diff=12'hFFF, brr=1.
3. Boundaries:
   - a=12'hFFF, b=12'hFFF, bin=1 -> diff=12'hFFF, brr=1
   - a=12'hFFF, b=0, bin=1 -> diff=12'hFFE, brr=0
   - a=12'h800, b=12'h001, bin=0 -> diff=12'h7FF, brr=0 (borrow ripples across all digits)
4. Accept a=100, b=37. At E2, assert start with a=1, b=2, and change a/b every cycle until done -> result still diff=63, brr=0. Exactly one done pulse.
5. Drive rst_n=0 on the edge after E2 of a running operation -> next cycle busy=0, done=0, diff=0, brr=0, and no done appears later. A following start with a=7, b=3, bin=0 yields diff=4, brr=0 with normal latency.
6. Hold start=1 continuously with a=10, b=20 -> done pulses every DIGITS+2=6 cycles; each result is diff=12'hFF6, brr=1. A randomized sweep of 200 operands matches {brr,diff} = {1'b0,a} - {1'b0,b} - bin computed at W+1 bits.
